// File: rtl/tx_packet_builder.sv
// rtl/tx_packet_builder.sv - USB full-speed TX byte sequencer: SYNC, PID, payload, CRC16, EOP.
// Optional abort input is compiled in with TX_ABORT_EN.

module tx_crc16_byte (
    input  logic [15:0] i_crc,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);
    logic [15:0] w_acc;

    // Reflected form of x^16+x^15+x^2+1, data consumed LSB first.
    always_comb begin
        w_acc = i_crc;
        for (int i = 0; i < 8; i++) begin
            if (w_acc[0] ^ i_data[i]) begin
                w_acc = (w_acc >> 1) ^ 16'hA001;
            end else begin
                w_acc = w_acc >> 1;
            end
        end
        o_crc = w_acc;
    end
endmodule

module tx_packet_builder #(
    parameter int MAX_DATA_BYTES = 64
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
`ifdef TX_ABORT_EN
    input  logic       abort,
`endif
    input  logic [2:0] tx_packet,
    input  logic [6:0] data_count,
    input  logic [7:0] tx_data,
    output logic       get_tx_data,
    input  logic       byte_req,
    input  logic       eop_done,
    output logic [7:0] tx_byte,
    output logic       tx_byte_valid,
    output logic       send_eop,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_PID,
        S_FETCH,
        S_WAIT_DATA,
        S_DATA,
        S_CRC_LO,
        S_CRC_HI,
        S_EOP,
        S_DONE
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_DATA_BYTES);

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_pid;
    logic        r_is_data;
    logic [6:0]  r_remaining;
    logic [15:0] r_crc;
    logic [7:0]  r_data;
    logic        r_tx_error;
    logic        r_aborted;

    logic [3:0]  w_pid;
    logic        w_is_data;
    logic        w_pid_ok;
    logic        w_cmd_ok;
    logic        w_in_frame;
    logic        w_abort;
    logic [15:0] w_crc_next;

    tx_crc16_byte u_crc (
        .i_crc  (r_crc),
        .i_data (tx_data),
        .o_crc  (w_crc_next)
    );

    always_comb begin
        w_pid     = 4'h0;
        w_is_data = 1'b0;
        w_pid_ok  = 1'b1;
        case (tx_packet)
            3'b001: begin w_pid = 4'b0011; w_is_data = 1'b1; end
            3'b010: begin w_pid = 4'b1011; w_is_data = 1'b1; end
            3'b011: w_pid = 4'b0010;
            3'b100: w_pid = 4'b1010;
            3'b101: w_pid = 4'b1110;
            default: w_pid_ok = 1'b0;
        endcase
        w_cmd_ok = w_pid_ok && !(w_is_data && ({1'b0, data_count} > MAX_CNT));
    end

    assign w_in_frame = (r_state == S_SYNC) || (r_state == S_PID) || (r_state == S_FETCH) ||
                        (r_state == S_WAIT_DATA) || (r_state == S_DATA) ||
                        (r_state == S_CRC_LO) || (r_state == S_CRC_HI);

`ifdef TX_ABORT_EN
    assign w_abort = abort && w_in_frame;
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_EOP;
        end else begin
            case (r_state)
                S_IDLE:      if (start && w_cmd_ok) w_next = S_SYNC;
                S_SYNC:      if (byte_req) w_next = S_PID;
                S_PID: begin
                    if (byte_req) begin
                        if (!r_is_data)               w_next = S_EOP;
                        else if (r_remaining == 7'd0) w_next = S_CRC_LO;
                        else                          w_next = S_FETCH;
                    end
                end
                S_FETCH:     w_next = S_WAIT_DATA;
                S_WAIT_DATA: w_next = S_DATA;
                S_DATA:      if (byte_req) w_next = (r_remaining != 7'd0) ? S_FETCH : S_CRC_LO;
                S_CRC_LO:    if (byte_req) w_next = S_CRC_HI;
                S_CRC_HI:    if (byte_req) w_next = S_EOP;
                S_EOP:       if (eop_done) w_next = S_DONE;
                S_DONE:      w_next = S_IDLE;
                default:     w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_pid       <= 4'h0;
            r_is_data   <= 1'b0;
            r_remaining <= 7'd0;
            r_crc       <= 16'hFFFF;
            r_data      <= 8'h00;
            r_tx_error  <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_tx_error <= 1'b0;
            if (w_abort) begin
                r_tx_error <= 1'b1;
                r_aborted  <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cmd_ok) begin
                                r_pid       <= w_pid;
                                r_is_data   <= w_is_data;
                                r_remaining <= w_is_data ? data_count : 7'd0;
                                r_crc       <= 16'hFFFF;
                                r_aborted   <= 1'b0;
                            end else begin
                                r_tx_error  <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_DATA: begin
                        r_data      <= tx_data;
                        r_crc       <= w_crc_next;
                        r_remaining <= r_remaining - 7'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // The CRC goes out inverted, low byte first.
    always_comb begin
        tx_byte = 8'h00;
        case (r_state)
            S_SYNC:   tx_byte = 8'h80;
            S_PID:    tx_byte = {~r_pid, r_pid};
            S_DATA:   tx_byte = r_data;
            S_CRC_LO: tx_byte = ~r_crc[7:0];
            S_CRC_HI: tx_byte = ~r_crc[15:8];
            default:  tx_byte = 8'h00;
        endcase
    end

    assign tx_byte_valid = (r_state == S_SYNC) || (r_state == S_PID) || (r_state == S_DATA) ||
                           (r_state == S_CRC_LO) || (r_state == S_CRC_HI);
    assign get_tx_data   = (r_state == S_FETCH);
    assign send_eop      = (r_state == S_EOP);
    assign tx_busy       = (r_state != S_IDLE);
    assign tx_done       = (r_state == S_DONE) && !r_aborted;
    assign tx_error      = r_tx_error;

endmodule

// File: tb/tb_tx_packet_builder.sv
// tb/tb_tx_packet_builder.sv - randomized bench for tx_packet_builder against a packet-level reference model.
module tb_tx_packet_builder;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [2:0] tx_packet = 3'b000;
    logic [6:0] data_count = 7'd0;
    logic [7:0] tx_data = 8'h00;
    logic       get_tx_data;
    logic       byte_req = 1'b0;
    logic       eop_done = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_byte_valid;
    logic       send_eop;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int n_vec  = 0;
    int n_miss = 0;

    logic [7:0] pid_tab [0:7] = '{8'h00, 8'hC3, 8'h4B, 8'hD2, 8'h5A, 8'h1E, 8'h00, 8'h00};

    always #5 clk = ~clk;

    tx_packet_builder #(.MAX_DATA_BYTES(64)) dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .start         (start),
`ifdef TX_ABORT_EN
        .abort         (abort),
`endif
        .tx_packet     (tx_packet),
        .data_count    (data_count),
        .tx_data       (tx_data),
        .get_tx_data   (get_tx_data),
        .byte_req      (byte_req),
        .eop_done      (eop_done),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .send_eop      (send_eop),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // CRC-16/USB in its textbook MSB-first form, reflected and inverted at the end.
    function automatic logic [15:0] crc_tail(input logic [7:0] d[$]);
        logic [15:0] c;
        logic [15:0] r;
        logic        fb;
        c = 16'hFFFF;
        foreach (d[k]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ d[k][i];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h8005;
            end
        end
        for (int i = 0; i < 16; i++) r[i] = c[15 - i];
        return r ^ 16'hFFFF;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_byte"},  tx_byte, 0);
        check_val({tag, "_valid"}, tx_byte_valid, 0);
        check_val({tag, "_eop"},   send_eop, 0);
        check_val({tag, "_busy"},  tx_busy, 0);
        check_val({tag, "_done"},  tx_done, 0);
        check_val({tag, "_err"},   tx_error, 0);
        check_val({tag, "_get"},   get_tx_data, 0);
    endtask

    task automatic reject(input logic [2:0] typ, input int cnt);
        @(posedge clk); #1;
        start = 1'b1; tx_packet = typ; data_count = 7'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("rej_err", tx_error, 1);
        check_val("rej_busy", tx_busy, 0);
        check_val("rej_valid", tx_byte_valid, 0);
        @(posedge clk); #1;
        check_val("rej_err_clr", tx_error, 0);
        check_val("rej_busy2", tx_busy, 0);
    endtask

    // mode: 0 normal, 1 reset inside DATA, 2 abort inside DATA
    task automatic send_packet(input logic [2:0] typ, input int cnt, input bit fixed,
                               input bit bp, input bit stray, input int mode);
        logic [7:0] pay[$];
        logic [7:0] fifo_q[$];
        logic [7:0] exp_q[$];
        logic [7:0] got_q[$];
        logic [15:0] crc;
        logic [7:0] held;
        bit   is_data;
        bit   bp_done = 0;
        bit   stray_done = 0;
        bit   eop_seen = 0;
        int   gets = 0;
        int   errs = 0;
        int   dones = 0;
        int   cyc = 0;
        int   idx;
        int   bad;
        int   g0;

        is_data = (typ == 3'b001) || (typ == 3'b010);
        if (is_data) begin
            for (int k = 0; k < cnt; k++) pay.push_back(fixed ? 8'(k + 1) : 8'($urandom));
        end
        fifo_q = pay;
        exp_q.push_back(8'h80);
        exp_q.push_back(pid_tab[typ]);
        if (is_data) begin
            foreach (pay[k]) exp_q.push_back(pay[k]);
            crc = crc_tail(pay);
            exp_q.push_back(crc[7:0]);
            exp_q.push_back(crc[15:8]);
        end

        @(posedge clk); #1;
        start = 1'b1; tx_packet = typ; data_count = 7'(cnt);
        @(posedge clk); #1;
        start = 1'b0;
        check_val("lat_valid", tx_byte_valid, 1);

        while (dones == 0 && cyc < 3000) begin
            byte_req = 1'b0; eop_done = 1'b0; start = 1'b0;
            idx = got_q.size();
            if (tx_error) errs++;
            if (get_tx_data) begin
                gets++;
                tx_data = (fifo_q.size() > 0) ? fifo_q.pop_front() : 8'($urandom);
            end
            if (mode != 0 && is_data && tx_byte_valid && idx >= 3 && idx < 2 + cnt) begin
                if (mode == 1) begin
                    @(negedge clk);
                    n_rst = 1'b0;
                    #1;
                    check_idle_outputs("rst_mid");
                    bad = 0;
                    repeat (3) begin
                        @(posedge clk); #1;
                        if (send_eop || tx_busy) bad++;
                    end
                    check_val("rst_quiet", bad, 0);
                    n_rst = 1'b1;
                    @(posedge clk); #1;
                end
`ifdef TX_ABORT_EN
                if (mode == 2) begin
                    abort = 1'b1;
                    @(posedge clk); #1;
                    abort = 1'b0;
                    check_val("abt_valid", tx_byte_valid, 0);
                    check_val("abt_err", tx_error, 1);
                    check_val("abt_eop", send_eop, 1);
                    eop_done = 1'b1;
                    @(posedge clk); #1;
                    eop_done = 1'b0;
                    check_val("abt_no_done", tx_done, 0);
                    check_val("abt_busy", tx_busy, 1);
                    check_val("abt_err_clr", tx_error, 0);
                    @(posedge clk); #1;
                    check_val("abt_idle", tx_busy, 0);
                    check_val("abt_no_done2", tx_done, 0);
                end
`endif
                break;
            end
            if (tx_done) begin
                dones++;
            end else if (send_eop) begin
                eop_seen = 1;
                eop_done = ($urandom_range(0, 2) == 0);
                byte_req = $urandom_range(0, 1);
            end else if (tx_byte_valid) begin
                if (bp && !bp_done && is_data && idx >= 2 && idx < 2 + cnt) begin
                    held = tx_byte; bad = 0; g0 = gets;
                    repeat (20) begin
                        @(posedge clk); #1;
                        if (tx_byte !== held || tx_byte_valid !== 1'b1) bad++;
                        if (get_tx_data) gets++;
                    end
                    check_val("bp_stable", bad, 0);
                    check_val("bp_no_get", gets, g0);
                    bp_done = 1;
                end
                if (stray && !stray_done && is_data && idx >= 2 && idx < 2 + cnt) begin
                    start = 1'b1; tx_packet = 3'b110; data_count = 7'd0;
                    stray_done = 1;
                end
                if ($urandom_range(0, 3) != 0) begin
                    got_q.push_back(tx_byte);
                    byte_req = 1'b1;
                end
            end else begin
                byte_req = $urandom_range(0, 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        byte_req = 1'b0; eop_done = 1'b0; start = 1'b0;

        if (mode == 0) begin
            check_val("pkt_done", dones, 1);
            check_val("pkt_len", got_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size(); k++) begin
                check_val($sformatf("byte%0d_t%0d_n%0d", k, typ, cnt),
                          (k < got_q.size()) ? {24'h0, got_q[k]} : 32'hDEAD, {24'h0, exp_q[k]});
            end
            check_val("pkt_gets", gets, is_data ? cnt : 0);
            check_val("pkt_errs", errs, 0);
            check_val("pkt_eop", eop_seen, 1);
            @(posedge clk); #1;
            check_val("done_pulse", tx_done, 0);
            check_val("idle_after", tx_busy, 0);
        end
    endtask

    initial begin
        int typ;
        int cnt;
        n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        n_rst = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("post_reset");

        send_packet(3'b011, 0, 0, 0, 0, 0);
        send_packet(3'b010, 0, 0, 0, 0, 0);
        send_packet(3'b001, 4, 1, 0, 0, 0);
        send_packet(3'b010, 64, 0, 0, 0, 0);
        send_packet(3'b100, 100, 0, 0, 0, 0);
        send_packet(3'b101, 0, 0, 0, 0, 0);

        reject(3'b110, 0);
        reject(3'b000, 5);
        reject(3'b111, 1);
        reject(3'b001, 65);
        reject(3'b010, 127);

        send_packet(3'b001, 6, 0, 1, 1, 0);
        send_packet(3'b001, 8, 0, 0, 0, 1);
        send_packet(3'b010, 5, 0, 0, 0, 0);
`ifdef TX_ABORT_EN
        send_packet(3'b001, 8, 0, 0, 0, 2);
        send_packet(3'b011, 0, 0, 0, 0, 0);
`endif

        repeat (25) begin
            typ = $urandom_range(1, 5);
            cnt = $urandom_range(0, 64);
            send_packet(3'(typ), cnt, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
